// File: rtl/hrm_inbox_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hrm_inbox_fifo_if                                            |
// | Description : Producer / control-unit bundle for the HRM inbox FIFO.       |
// |               almost_full exists only with INBOX_ALMOST_FULL_EN defined.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface hrm_inbox_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 5
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic                clr;
  logic                rIn;
  logic                inEmpty;
  logic [DATA_W-1:0]   dout;
  logic [DEPTH_LOG2:0] level;
  logic                underflow;
`ifdef INBOX_ALMOST_FULL_EN
  logic                almost_full;

  modport slave (
    input  in_data, in_valid, clr, rIn,
    output in_ready, inEmpty, dout, level, underflow, almost_full
  );

  modport master (
    output in_data, in_valid, clr, rIn,
    input  in_ready, inEmpty, dout, level, underflow, almost_full
  );
`else
  modport slave (
    input  in_data, in_valid, clr, rIn,
    output in_ready, inEmpty, dout, level, underflow
  );

  modport master (
    output in_data, in_valid, clr, rIn,
    input  in_ready, inEmpty, dout, level, underflow
  );
`endif
endinterface
`default_nettype wire

// File: rtl/hrm_inbox_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hrm_inbox_fifo                                               |
// | Description : Circular inbox FIFO for the HRM CPU with held pop register.  |
// |               Optional almost_full output: define INBOX_ALMOST_FULL_EN.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hrm_inbox_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 5,
  parameter int AF_LEVEL   = 28
) (
  input wire              clk,
  input wire              i_rst,
  hrm_inbox_fifo_if.slave bus
);

  localparam int                  C_DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL  = (DEPTH_LOG2 + 1)'(C_DEPTH);

  logic [DATA_W-1:0]     mem_q [C_DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  underflow_q, underflow_d;
  logic                  w_push, w_pop;

  assign bus.in_ready  = (count_q != c_FULL);
  assign bus.inEmpty   = (count_q == '0);
  assign bus.dout      = dout_q;
  assign bus.level     = count_q;
  assign bus.underflow = underflow_q;

  // Full blocks the push and empty blocks the pop, so there is never a bypass.
  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.rIn && !bus.inEmpty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    underflow_d = underflow_q;
    if (bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      dout_d      = '0;
      underflow_d = 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
      end
      if (bus.rIn && bus.inEmpty) begin
        underflow_d = 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push && !bus.clr) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

`ifdef INBOX_ALMOST_FULL_EN
  logic almost_full_q, almost_full_d;

  assign almost_full_d   = !bus.clr && (int'(count_d) >= AF_LEVEL);
  assign bus.almost_full = almost_full_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end
`else
  localparam int c_unused_af_level = AF_LEVEL;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hrm_inbox_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hrm_inbox_fifo                                            |
// | Description : Self-checking bench for hrm_inbox_fifo against a queue model.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_hrm_inbox_fifo;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 5;
  localparam int DEPTH      = 32;
  localparam int AF_LEVEL   = 28;

  logic clk = 1'b0;
  logic i_rst;

  always #5 clk = ~clk;

  hrm_inbox_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  hrm_inbox_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .AF_LEVEL  (AF_LEVEL)
  ) dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of words plus the held output and sticky flag.
  logic [7:0] m_q [$];
  logic [7:0] m_dout;
  logic       m_uf;
  logic       m_af;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_uf   = 1'b0;
    m_af   = 1'b0;
  endtask

  task automatic model_edge();
    bit empty, full;
    empty = (m_q.size() == 0);
    full  = (m_q.size() == DEPTH);
    if (bus.clr) begin
      model_reset();
    end else begin
      if (bus.rIn && empty) m_uf = 1'b1;
      if (bus.rIn && !empty) m_dout = m_q.pop_front();
      if (bus.in_valid && !full) m_q.push_back(bus.in_data);
      m_af = (m_q.size() >= AF_LEVEL);
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".level"},     32'(bus.level),     32'(m_q.size()));
    check_eq({ctx, ".inEmpty"},   32'(bus.inEmpty),   32'(m_q.size() == 0));
    check_eq({ctx, ".in_ready"},  32'(bus.in_ready),  32'(m_q.size() != DEPTH));
    check_eq({ctx, ".dout"},      32'(bus.dout),      32'(m_dout));
    check_eq({ctx, ".underflow"}, 32'(bus.underflow), 32'(m_uf));
`ifdef INBOX_ALMOST_FULL_EN
    check_eq({ctx, ".almost_full"}, 32'(bus.almost_full), 32'(m_af));
`endif
  endtask

  task automatic drive(input string ctx, input logic v, input logic [7:0] d,
                       input logic r, input logic c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rIn      = r;
    bus.clr      = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  initial begin
    int pv, pr;
    i_rst        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rIn      = 1'b0;
    bus.clr      = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Basic push/pop with held output.
    drive("push11", 1, 8'h11, 0, 0);
    drive("push22", 1, 8'h22, 0, 0);
    drive("push33", 1, 8'h33, 0, 0);
    drive("pop1",   0, 8'h00, 1, 0);
    drive("hold",   0, 8'h00, 0, 0);
    drive("hold",   0, 8'h00, 0, 0);
    drive("pop2",   0, 8'h00, 1, 0);
    drive("pop3",   0, 8'h00, 1, 0);
    drive("idle",   0, 8'h00, 0, 0);

    // Fill to full, reject extra word, pop once, then accept it.
    for (int i = 0; i < DEPTH; i++) drive("fill", 1, 8'(i), 0, 0);
    drive("full_rej", 1, 8'hAA, 0, 0);
    drive("full_pop", 1, 8'hAA, 1, 0);
    check_eq("full_pop.dout00", 32'(bus.dout), 32'h00);
    drive("refill",   1, 8'hAA, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive("drain", 0, 8'h00, 1, 0);
    check_eq("drain.lastAA", 32'(bus.dout), 32'hAA);

    // Interleaved pairs wrap both pointers.
    for (int i = 0; i < 40; i++) begin
      drive("wrap_push", 1, 8'($urandom), 0, 0);
      check_eq("wrap.level_le2", 32'(bus.level <= 2), 32'd1);
      drive("wrap_pop", 0, 8'h00, 1, 0);
    end

    // Underflow is sticky until clr.
    drive("uflow",     0, 8'h00, 1, 0);
    drive("uf_push55", 1, 8'h55, 0, 0);
    drive("uf_pop55",  0, 8'h00, 1, 0);
    drive("uf_clr",    0, 8'h00, 0, 1);

    // Same-cycle push and pop, empty and non-empty.
    drive("pp_empty", 1, 8'h77, 1, 0);
    drive("pp_one",   1, 8'h88, 1, 0);
    check_eq("pp_one.dout77", 32'(bus.dout), 32'h77);
    drive("pp_drain", 0, 8'h00, 1, 0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) drive("pre_rst", 1, 8'(8'hC0 + i), 0, 0);
    drive("pre_pop", 0, 8'h00, 1, 0);
    drive("pre_push", 1, 8'hC5, 0, 0);
    bus.in_valid = 1'b0;
    bus.rIn      = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    i_rst = 1'b0;

    // Walk across the almost-full threshold and back.
    for (int i = 0; i < AF_LEVEL; i++) drive("af_fill", 1, 8'(i + 3), 0, 0);
    drive("af_pop", 0, 8'h00, 1, 0);
    drive("af_push", 1, 8'h5A, 0, 0);
    drive("af_clr", 0, 8'h00, 0, 1);

    // Randomised traffic with biased phases to reach both full and empty.
    for (int ph = 0; ph < 3; ph++) begin
      pv = (ph == 0) ? 90 : (ph == 1) ? 20 : 55;
      pr = (ph == 0) ? 20 : (ph == 1) ? 90 : 50;
      for (int i = 0; i < 600; i++) begin
        drive("rand",
              ($urandom_range(99) < pv),
              8'($urandom),
              ($urandom_range(99) < pr),
              ($urandom_range(199) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
